// File: rtl/seg_disp_pkg.sv
// Shared definitions for the seven-segment display path: segment bit
// positions on the bus, the all-off pattern and the per-slot scan states.
package seg_disp_pkg;

    // Segment bit positions within one digit pattern (1 = segment lit).
    localparam int SEG_G  = 0;
    localparam int SEG_F  = 1;
    localparam int SEG_E  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_A  = 4;
    localparam int SEG_B  = 5;
    localparam int SEG_DP = 6;
    localparam int SEG_C  = 7;

    localparam int SEG_BITS = 8;

    // Logical pattern with every segment dark.
    localparam logic [SEG_BITS-1:0] SEG_OFF = 8'h00;

    // A digit slot starts blanked and then shows its digit.
    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_t;

endpackage

// File: rtl/seg_scan_timer.sv
// Slot timer for the scan multiplexer: counts cycles within a digit slot,
// walks the digit index, and flags the blank/show phase, the last cycle of
// the frame and the first cycle of the frame.
module seg_scan_timer
    import seg_disp_pkg::*;
#(
    parameter int NUM_DIGITS   = 3,
    parameter int PRESCALE     = 1000,
    parameter int BLANK_CYCLES = 4,
    parameter int IDX_W        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    output logic             slot_show_o,
    output logic [IDX_W-1:0] digit_idx_o,
    output logic             frame_boundary_o,
    output logic             frame_start_pulse_o
);

    localparam int CNT_W = $clog2(PRESCALE);

    localparam logic [CNT_W-1:0] CNT_ZERO       = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_LAST       = CNT_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_ZERO       = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0] IDX_LAST       = IDX_W'(NUM_DIGITS - 1);

    scan_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             slot_end_s;

    assign slot_end_s = (cnt_q == CNT_LAST);

    // Phase within the slot: blank for the first BLANK_CYCLES, then show.
    always_comb begin
        state_d = state_q;
        case (state_q)
            BLANK: begin
                if (cnt_q == CNT_BLANK_LAST) begin
                    state_d = SHOW;
                end else begin
                    state_d = BLANK;
                end
            end
            SHOW: begin
                if (slot_end_s) begin
                    state_d = BLANK;
                end else begin
                    state_d = SHOW;
                end
            end
            default: state_d = BLANK;
        endcase
    end

    // Slot cycle counter and digit index; the index wraps after the last digit.
    always_comb begin
        cnt_d = cnt_q;
        idx_d = idx_q;
        if (slot_end_s) begin
            cnt_d = CNT_ZERO;
            if (idx_q == IDX_LAST) begin
                idx_d = IDX_ZERO;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
            idx_d = idx_q;
        end
    end

    // Timer state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= BLANK;
            cnt_q   <= CNT_ZERO;
            idx_q   <= IDX_ZERO;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
        end
    end

    assign slot_show_o         = (state_q == SHOW);
    assign digit_idx_o         = idx_q;
    assign frame_boundary_o    = slot_end_s && (idx_q == IDX_LAST);
    assign frame_start_pulse_o = (cnt_q == CNT_ZERO) && (idx_q == IDX_ZERO);

endmodule

// File: rtl/seven_seg_scan_mux.sv
// Time-multiplexes NUM_DIGITS segment patterns onto one segment bus with
// one-hot digit enables. New frames enter a shadow register through a
// valid/ready handshake and are promoted to the displayed set only at a
// frame boundary, so a partially updated frame is never shown.
module seven_seg_scan_mux
    import seg_disp_pkg::*;
#(
    parameter int NUM_DIGITS   = 3,
    parameter int SEG_W        = 8,
    parameter int PRESCALE     = 1000,
    parameter int BLANK_CYCLES = 4,
    parameter bit ACTIVE_LOW   = 1'b0
) (
    input  logic                        input_clock,
    input  logic                        input_reset_n,
    input  logic                        frame_valid,
    output logic                        frame_ready,
    input  logic [NUM_DIGITS*SEG_W-1:0] frame_data,
    output logic [SEG_W-1:0]            seg_out,
    output logic [NUM_DIGITS-1:0]       digit_en,
    output logic                        frame_start
);

    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int FRAME_W = NUM_DIGITS * SEG_W;

    localparam logic [SEG_W-1:0]      SEG_DARK = SEG_W'(SEG_OFF);
    localparam logic [NUM_DIGITS-1:0] EN_NONE  = {NUM_DIGITS{1'b0}};
    localparam logic [FRAME_W-1:0]    FRAME_0  = {FRAME_W{1'b0}};

    // Pin-level idle levels: everything dark and deselected.
    localparam logic [SEG_W-1:0]      SEG_IDLE = ACTIVE_LOW ? {SEG_W{1'b1}} : SEG_DARK;
    localparam logic [NUM_DIGITS-1:0] EN_IDLE  = ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : EN_NONE;

    if ((PRESCALE <= BLANK_CYCLES) || (BLANK_CYCLES < 1) || (NUM_DIGITS < 1)) begin : g_param_check
        $error("seven_seg_scan_mux: need PRESCALE > BLANK_CYCLES >= 1 and NUM_DIGITS >= 1");
    end

    logic             slot_show_s;
    logic [IDX_W-1:0] digit_idx_s;
    logic             frame_boundary_s;
    logic             frame_start_pulse_s;

    seg_scan_timer #(
        .NUM_DIGITS   (NUM_DIGITS),
        .PRESCALE     (PRESCALE),
        .BLANK_CYCLES (BLANK_CYCLES),
        .IDX_W        (IDX_W)
    ) u_timer (
        .clk_i               (input_clock),
        .rst_ni              (input_reset_n),
        .slot_show_o         (slot_show_s),
        .digit_idx_o         (digit_idx_s),
        .frame_boundary_o    (frame_boundary_s),
        .frame_start_pulse_o (frame_start_pulse_s)
    );

    logic [FRAME_W-1:0]    shadow_q, shadow_d;
    logic [FRAME_W-1:0]    active_q, active_d;
    logic                  pending_q, pending_d;
    logic                  boundary_q;
    logic                  frame_start_q;
    logic [SEG_W-1:0]      seg_out_q, seg_out_d;
    logic [NUM_DIGITS-1:0] digit_en_q, digit_en_d;
    logic [SEG_W-1:0]      seg_raw_s;
    logic [NUM_DIGITS-1:0] en_raw_s;
    logic                  accept_s;
    logic                  transfer_s;
    int                    sel_base_s;

    // The output registers lag the timer by one cycle, so the boundary is
    // delayed by the same amount to keep the hand-over aligned with the pins.
    assign accept_s   = frame_valid && !pending_q;
    assign transfer_s = boundary_q && pending_q;
    assign sel_base_s = int'(digit_idx_s) * SEG_W;

    // Shadow capture on accept, shadow-to-active promotion at the boundary.
    always_comb begin
        shadow_d  = shadow_q;
        active_d  = active_q;
        pending_d = pending_q;
        if (accept_s) begin
            shadow_d  = frame_data;
            pending_d = 1'b1;
        end else if (transfer_s) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end else begin
            pending_d = pending_q;
        end
    end

    // Select the current digit's pattern and enable, then apply pin polarity.
    always_comb begin
        seg_raw_s = SEG_DARK;
        en_raw_s  = EN_NONE;
        if (slot_show_s) begin
            seg_raw_s = active_q[sel_base_s +: SEG_W];
            en_raw_s  = NUM_DIGITS'(1) << digit_idx_s;
        end else begin
            seg_raw_s = SEG_DARK;
            en_raw_s  = EN_NONE;
        end
        seg_out_d  = ACTIVE_LOW ? ~seg_raw_s : seg_raw_s;
        digit_en_d = ACTIVE_LOW ? ~en_raw_s : en_raw_s;
    end

    // Frame buffers and handshake state.
    always_ff @(posedge input_clock or negedge input_reset_n) begin
        if (!input_reset_n) begin
            shadow_q   <= FRAME_0;
            active_q   <= FRAME_0;
            pending_q  <= 1'b0;
            boundary_q <= 1'b0;
        end else begin
            shadow_q   <= shadow_d;
            active_q   <= active_d;
            pending_q  <= pending_d;
            boundary_q <= frame_boundary_s;
        end
    end

    // Registered pin drivers.
    always_ff @(posedge input_clock or negedge input_reset_n) begin
        if (!input_reset_n) begin
            seg_out_q     <= SEG_IDLE;
            digit_en_q    <= EN_IDLE;
            frame_start_q <= 1'b0;
        end else begin
            seg_out_q     <= seg_out_d;
            digit_en_q    <= digit_en_d;
            frame_start_q <= frame_start_pulse_s;
        end
    end

    assign seg_out     = seg_out_q;
    assign digit_en    = digit_en_q;
    assign frame_start = frame_start_q;
    assign frame_ready = !pending_q;

endmodule
